// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, controller states and
// small decode helpers used by the controller decoder and the hazard unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MdMult  = 3'd0,
        MdMultu = 3'd1,
        MdDiv   = 3'd2,
        MdDivu  = 3'd3,
        MdMthi  = 3'd4,
        MdMtlo  = 3'd5,
        MdMfhi  = 3'd6,
        MdMflo  = 3'd7
    } md_op_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_t;

    // Multi-cycle ops occupy the low half of the encoding space.
    function automatic logic op_is_long(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one operation,
// including divide-by-zero and signed-overflow results.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0]        sprod;
    logic [63:0]        uprod;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        sdiv_b;
    logic [31:0]        udiv_b;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic [31:0]        uquot;
    logic [31:0]        urem;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Special cases get a harmless divisor; their results are substituted below.
    assign sdiv_b = (div_zero || div_ovf) ? 32'd1 : b;
    assign udiv_b = div_zero ? 32'd1 : b;

    assign squot = $signed(a) / $signed(sdiv_b);
    assign srem  = $signed(a) % $signed(sdiv_b);
    assign uquot = a / udiv_b;
    assign urem  = a % udiv_b;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op_t'(op))
            MdMult: begin
                res_hi = sprod[63:32];
                res_lo = sprod[31:0];
            end
            MdMultu: begin
                res_hi = uprod[63:32];
                res_lo = uprod[31:0];
            end
            MdDiv: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = srem;
                    res_lo = squot;
                end
            end
            MdDivu: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = urem;
                    res_lo = uquot;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as fixed-latency multi-cycle
// operations and serves MTHI/MTLO/MFHI/MFLO.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_e,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic [31:0]      shadow_lo_q, shadow_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;

    md_calc u_md_calc (
        .op     (md_op_e),
        .a      (a_e),
        .b      (b_e),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        // Cancel beats both a new start and a completing operation.
        if (cancel) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_e) begin
                        if (op_is_long(md_op_e)) begin
                            shadow_hi_d = calc_hi;
                            shadow_lo_d = calc_lo;
                            cnt_d       = op_is_div(md_op_e) ? CNT_W'(DIV_CYCLES - 1)
                                                             : CNT_W'(MULT_CYCLES - 1);
                            state_d     = StRun;
                        end else if (md_op_e == MdMthi) begin
                            hi_d = a_e;
                        end else if (md_op_e == MdMtlo) begin
                            lo_d = a_e;
                        end
                    end
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        hi_d    = shadow_hi_q;
                        lo_d    = shadow_lo_q;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (md_op_e == MdMfhi) begin
            rd_data = hi_q;
        end else if (md_op_e == MdMflo) begin
            rd_data = lo_q;
        end
    end

    assign busy = (state_q == StRun);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed boundary cases plus randomized traffic compared
// every cycle against an arithmetic reference model.
module tb_md_unit;

    localparam int MultN = 5;
    localparam int DivN  = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_e = 1'b0;
    logic [2:0]  md_op_e = 3'd0;
    logic [31:0] a_e     = 32'd0;
    logic [31:0] b_e     = 32'd0;
    logic        cancel  = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, pending result and busy cycles still to run.
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;
    int          m_left = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start_e (start_e),
        .md_op_e (md_op_e),
        .a_e     (a_e),
        .b_e     (b_e),
        .cancel  (cancel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh,
                                   output logic [31:0] rl);
        longint          sa, sb, r;
        longint unsigned ua, ub, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            3'd0: begin r = sa * sb; rh = r[63:32]; rl = r[31:0]; end
            3'd1: begin ur = ua * ub; rh = ur[63:32]; rl = ur[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    r = sa / sb; rl = r[31:0];
                    r = sa % sb; rh = r[31:0];
                end else begin
                    ur = ua / ub; rl = ur[31:0];
                    ur = ua % ub; rh = ur[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (cancel) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start_e) begin
            if (md_op_e < 3'd4) begin
                ref_op(md_op_e, a_e, b_e, p_hi, p_lo);
                m_left = (md_op_e >= 3'd2) ? DivN : MultN;
            end else if (md_op_e == 3'd4) begin
                m_hi = a_e;
            end else if (md_op_e == 3'd5) begin
                m_lo = a_e;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_rd;
            exp_rd = (md_op_e == 3'd6) ? m_hi : (md_op_e == 3'd7) ? m_lo : 32'd0;
            check("busy", 32'(busy), 32'(m_left > 0));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("rd_data", rd_data, exp_rd);
        end
    end

    always @(posedge clk) begin
        if (reset_n && start_e && busy) begin
            errors++;
            $display("FAIL start_while_busy: got start_e=1 busy=1 required no start while busy");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        tick();
        start_e = 1'b1;
        md_op_e = op;
        a_e     = a;
        b_e     = b;
        tick();
        start_e = 1'b0;
        a_e     = $urandom;
        b_e     = $urandom;
        md_op_e = ($urandom % 2 == 0) ? 3'd6 : 3'd7;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] v);
        tick();
        start_e = 1'b1;
        md_op_e = op;
        a_e     = v;
        tick();
        start_e = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset_n = 1'b1;

        issue(3'd0, -32'sd3, 32'd7);
        wait_idle("mult", MultN);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu", MultN);
        check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'd2, -32'sd7, 32'd2);
        wait_idle("div", DivN);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        issue(3'd3, 32'd7, 32'd0);
        wait_idle("divu0", DivN);
        check("divu0_hi", hi, 32'd7);
        check("divu0_lo", lo, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf", DivN);
        check("divovf_hi", hi, 32'd0);
        check("divovf_lo", lo, 32'h8000_0000);

        write_reg(3'd4, 32'h55);
        write_reg(3'd5, 32'h1234);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_busy", 32'(busy), 32'd0);
        md_op_e = 3'd7;
        #1;
        check("mflo_rd", rd_data, 32'h1234);
        md_op_e = 3'd6;
        #1;
        check("mfhi_rd", rd_data, 32'h55);

        issue(3'd0, 32'd2, 32'd3);
        md_op_e = 3'd7;
        #1;
        check("midop_rd", rd_data, 32'h1234);
        wait_idle("mult23", MultN);
        check("mult23_lo", lo, 32'd6);

        issue(3'd2, 32'd100, 32'd7);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        repeat (DivN) tick();
        check("cancel_hi", hi, 32'd0);
        check("cancel_lo", lo, 32'd6);

        issue(3'd2, 32'd100, 32'd7);
        repeat (DivN - 1) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_done_busy", 32'(busy), 32'd0);
        check("cancel_done_hi", hi, 32'd0);
        check("cancel_done_lo", lo, 32'd6);

        write_reg(3'd4, 32'hAAAA);
        issue(3'd0, 32'd5, 32'd5);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        issue(3'd0, 32'd9, 32'd9);
        wait_idle("mult_after_reset", MultN);
        check("mult_after_reset_lo", lo, 32'd81);

        for (int i = 0; i < 2000; i++) begin
            tick();
            cancel = ($urandom % 20 == 0);
            if (m_left == 0) begin
                start_e = ($urandom % 3 != 0);
                md_op_e = 3'($urandom % 8);
                a_e     = pick();
                b_e     = pick();
            end else begin
                start_e = 1'b0;
                md_op_e = 3'($urandom % 8);
                a_e     = $urandom;
                b_e     = $urandom;
            end
        end
        start_e = 1'b0;
        cancel  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
